// File: rtl/dmx_frame_tx.sv
// Self-refreshing DMX-512 universe transmitter: slot RAM image is replayed as
// break, MAB, start code, N slots and optional MBB, frame after frame.
module dmx_frame_tx #(
  parameter int CLK_DIV    = 100,
  parameter int MAX_SLOTS  = 512,
  parameter int SLOT_AW    = 9,
  parameter int BREAK_BITS = 23,
  parameter int MAB_BITS   = 3,
  parameter int MBB_BITS   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         start_code,
  input  logic [9:0]         slot_count,
  input  logic               wr_en,
  input  logic [SLOT_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  output logic               txd,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BREAK = 3'd1;
  localparam logic [2:0] S_MAB   = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_MBB   = 3'd6;

  localparam int              TW        = $clog2(CLK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [7:0]      BRK_LAST  = 8'(BREAK_BITS - 1);
  localparam logic [7:0]      MAB_LAST  = 8'(MAB_BITS - 1);
  localparam logic [7:0]      MBB_LAST  = 8'(MBB_BITS - 1);

  logic [7:0]    ram [MAX_SLOTS];
  logic [7:0]    rd_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    bit_q, bit_d;
  logic [9:0]    idx_q, idx_d, eff_q, eff_d;
  logic [7:0]    sc_q, sc_d, shift_q, shift_d;
  logic          txd_q, txd_d, busy_q, busy_d;
  logic          bit_end, frame_end;

  // Read-first RAM; the slot byte is fetched once, in the first START cycle.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    if (state_q == S_START && tick_q == '0 && bit_q == '0)
      rd_q <= ram[SLOT_AW'(idx_q - 10'd1)];
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    idx_d     = idx_q;
    eff_d     = eff_q;
    sc_d      = sc_q;
    shift_d   = shift_q;
    frame_end = 1'b0;
    bit_end   = (tick_q == TICK_LAST);
    if (bit_end) begin
      tick_d = '0;
      bit_d  = bit_q + 8'd1;
      if (state_q == S_DATA) shift_d = shift_q >> 1;
    end
    case (state_q)
      S_IDLE:  if (enable) state_d = S_BREAK;
      S_BREAK: if (bit_end && bit_q == BRK_LAST) state_d = S_MAB;
      S_MAB:   if (bit_end && bit_q == MAB_LAST) state_d = S_START;
      S_START: if (bit_end) begin
        state_d = S_DATA;
        shift_d = (idx_q == '0) ? sc_q : rd_q;
      end
      S_DATA:  if (bit_end && bit_q == 8'd7) state_d = S_STOP;
      S_STOP:  if (bit_end && bit_q == 8'd1) begin
        if (idx_q < eff_q) begin
          idx_d   = idx_q + 10'd1;
          state_d = S_START;
        end else if (MBB_BITS == 0) begin
          frame_end = 1'b1;
        end else begin
          state_d = S_MBB;
        end
      end
      S_MBB:   if (bit_end && bit_q == MBB_LAST) frame_end = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (frame_end) state_d = enable ? S_BREAK : S_IDLE;
    // Every state entry restarts the bit timer; BREAK entry latches frame setup.
    if (state_d != state_q || state_q == S_IDLE) begin
      tick_d = '0;
      bit_d  = '0;
    end
    if (state_d == S_BREAK && state_q != S_BREAK) begin
      idx_d = '0;
      eff_d = (slot_count > 10'(MAX_SLOTS)) ? 10'(MAX_SLOTS) : slot_count;
      sc_d  = start_code;
    end
    case (state_d)
      S_BREAK, S_START: txd_d = 1'b0;
      S_DATA:           txd_d = shift_d[0];
      default:          txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      eff_q   <= '0;
      sc_q    <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      eff_q   <= eff_d;
      sc_q    <= sc_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_end;

endmodule
